disc_input_framer: RTL

Upstream framing stage for `layer1_discriminator`. It accepts a serial valid/ready stream of Q8.8 samples and packs 256 of them into the discriminator's flattened 4096-bit input bus. It then pulses the discriminator's `start`, holds the bus stable while the MAC runs, and captures `score_out`/`decision_real` on `done`. Each result is presented on a valid/ready result port, together with framing and timeout error flags.

---
 rtl/gan_pkg.sv | 15 +
 rtl/disc_input_framer_frame_buffer.sv | 34 +++
 rtl/disc_input_framer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/gan_pkg.sv
// Shared constants and types for the discriminator front end.
// Q8.8 sample width, discriminator fan-in and framer states.
package gan_pkg;

   localparam int Q_DW        = 16;
   localparam int DISC_N_ELEM = 256;

   typedef enum logic [1:0] {
      ST_FILL,
      ST_LAUNCH,
      ST_WAIT,
      ST_RESULT
   } framer_state_t;

endpackage

// File: rtl/disc_input_framer_frame_buffer.sv
// Sample store for one discriminator frame.
// Element i is exposed at flat_o[(i+1)*DW-1 -: DW].
module frame_buffer
   import gan_pkg::*;
#(
   parameter int N  = DISC_N_ELEM,
   parameter int DW = Q_DW,
   parameter int IW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            we_i,
   input  logic [IW-1:0]   widx_i,
   input  logic [DW-1:0]   wdata_i,
   output logic [N*DW-1:0] flat_o
);

   logic [DW-1:0] mem_q [N];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[widx_i] <= wdata_i;
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign flat_o[g*DW +: DW] = mem_q[g];
   end

endmodule

// File: rtl/disc_input_framer.sv
// Packs a Q8.8 sample stream into the discriminator input bus,
// launches it, and returns the score on a valid/ready port.
module disc_input_framer
   import gan_pkg::*;
#(
   parameter int N_ELEM      = DISC_N_ELEM,
   parameter int DW          = Q_DW,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [DW-1:0]        s_data,
   input  logic                 s_last,
   output logic [DW*N_ELEM-1:0] disc_flat,
   output logic                 disc_start,
   input  logic [DW-1:0]        disc_score,
   input  logic                 disc_real,
   input  logic                 disc_done,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [DW-1:0]        m_score,
   output logic                 m_real,
   output logic                 m_err,
   output logic [15:0]          frame_cnt
);

   localparam int IW = (N_ELEM > 2) ? $clog2(N_ELEM) : 1;
   localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(N_ELEM - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   framer_state_t state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          frm_err_q, frm_err_d;
   logic [DW-1:0] score_q, score_d;
   logic          real_q, real_d;
   logic          err_q, err_d;
   logic [15:0]   cnt_q, cnt_d;
   logic          buf_we;

   frame_buffer #(
      .N  (N_ELEM),
      .DW (DW),
      .IW (IW)
   ) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (buf_we),
      .widx_i  (idx_q),
      .wdata_i (s_data),
      .flat_o  (disc_flat)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_FILL;
         idx_q     <= '0;
         tmo_q     <= '0;
         frm_err_q <= 1'b0;
         score_q   <= '0;
         real_q    <= 1'b0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         tmo_q     <= tmo_d;
         frm_err_q <= frm_err_d;
         score_q   <= score_d;
         real_q    <= real_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      tmo_d      = tmo_q;
      frm_err_d  = frm_err_q;
      score_d    = score_q;
      real_d     = real_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
      s_ready    = 1'b0;
      disc_start = 1'b0;
      m_valid    = 1'b0;
      buf_we     = 1'b0;
      unique case (state_q)
         ST_FILL: begin
            s_ready = 1'b1;
            if (s_valid) begin
               buf_we = 1'b1;
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = ST_LAUNCH;
                  if (!s_last) frm_err_d = 1'b1;
               end else if (s_last) begin
                  // Short frame: report an error without launching.
                  idx_d   = '0;
                  score_d = '0;
                  real_d  = 1'b0;
                  err_d   = 1'b1;
                  state_d = ST_RESULT;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         ST_LAUNCH: begin
            disc_start = 1'b1;
            tmo_d      = '0;
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            if (disc_done) begin
               score_d = disc_score;
               real_d  = disc_real;
               err_d   = frm_err_q;
               state_d = ST_RESULT;
            end else if (tmo_q == TMO_LAST) begin
               score_d = '0;
               real_d  = 1'b0;
               err_d   = 1'b1;
               state_d = ST_RESULT;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         ST_RESULT: begin
            m_valid = 1'b1;
            if (m_ready) begin
               cnt_d     = cnt_q + 16'd1;
               frm_err_d = 1'b0;
               state_d   = ST_FILL;
            end
         end
         default: state_d = ST_FILL;
      endcase
   end

   assign m_score   = score_q;
   assign m_real    = real_q;
   assign m_err     = err_q;
   assign frame_cnt = cnt_q;

endmodule
